usb_ddr3_stream_arbiter: RTL and testbench
==========================================

Name: usb_ddr3_stream_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single DDR3 write-stream sink (the ddr3_top s_* AXI-Stream port) between two 8-bit AXI-Stream requesters: USB bulk-out (port 0) and a local pattern/loopback source (port 1). A grant is held until the granted packet's tlast is accepted, so packets from the two sources never interleave. Packets longer than MAX_PACKET_LENGTH beats are truncated: tlast is forced on the output and the rest of the source packet is discarded.

Parameters:
MAX_PACKET_LENGTH, 512, maximum beats forwarded per packet; must be >= 2.
CBITS, $clog2(MAX_PACKET_LENGTH)+1, beat-counter width (derived; do not override).

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
en0_i  in  1  requester-0 enable; sampled only in IDLE.
en1_i  in  1  requester-1 enable; sampled only in IDLE.
s0_tvalid  in  1  requester-0 AXI-S valid.
s0_tready  out  1  requester-0 AXI-S ready.
s0_tkeep  in  1  requester-0 byte keep.
s0_tlast  in  1  requester-0 end of packet.
s0_tdata  in  8  requester-0 data.
s1_tvalid, s1_tready, s1_tkeep, s1_tlast, s1_tdata: same as s0_*, for requester 1.
m_tvalid  out  1  AXI-S valid to the DDR3 sink.
m_tready  in  1  sink ready.
m_tkeep  out  1  forwarded keep.
m_tlast  out  1  forwarded or forced tlast.
m_tdata  out  8  forwarded data.
grant_o  out  2  one-hot current grant; 2'b00 when IDLE.
busy_o  out  1  high in BUSY or DROP.
trunc_o  out  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset (synchronous): state=IDLE, grant_o=0, beat count=0, priority pointer selects s0, trunc_o=0. All outputs are 0 from the cycle after reset is sampled: m_tvalid, s*_tready, busy_o. A reset during BUSY or DROP abandons the packet immediately; no tlast is generated.
- IDLE:
  - m_tvalid=0 and both s*_tready=0.
  - Requests: req[i] = si_tvalid & eni_i.
  - One request: grant that requester. Both requests: grant the requester selected by the priority pointer.
  - Grant, beat count=0 and state=BUSY are registered. This gives a 1-cycle arbitration bubble: the first beat is transferred at the earliest 1 cycle after tvalid is seen in IDLE.
- BUSY, granted requester g:
  - Combinational pass-through, zero latency: m_tvalid=sg_tvalid, m_tdata/m_tkeep=sg_*, sg_tready=m_tready. The non-granted tready is 0.
  - m_tlast = sg_tlast | (count == MAX_PACKET_LENGTH-1).
  - A transfer (m_tvalid & m_tready) increments count. Beats with tkeep=0 still count.
  - Transfer with sg_tlast=1: state=IDLE, priority pointer set to the other requester, grant_o cleared.
  - Transfer with forced tlast and sg_tlast=0: trunc_o pulses for 1 cycle, state=DROP, priority pointer toggles.
  - Source tlast on exactly beat MAX_PACKET_LENGTH: treated as a normal end of packet. No truncation, no DROP.
- DROP:
  - m_tvalid=0 and sg_tready=1; source beats are discarded.
  - On sg_tvalid & sg_tlast: state=IDLE.
- Enables are ignored outside IDLE. Deasserting the granted enable mid-packet does not abort the packet.
- An AXI-S source must not drop tvalid once asserted; the arbiter relies on this and does not check it.
- busy_o = (state != IDLE). grant_o stays valid through DROP.

Test Plan:
- Single source: s0 sends a 4-beat packet (0x11..0x44) with m_tready=1 -> m_* carries 0x11..0x44, first beat 1 cycle after s0_tvalid, m_tlast on 0x44, grant_o=01 then 00.
- Contention: s0 and s1 both valid with 3-beat packets, back to back, after reset -> s0 packet first, then s1, then s0. Output packets never interleave.
- Backpressure: m_tready toggles 1,0,0,1,... during an 8-beat s1 packet -> data order is preserved, s1_tready mirrors m_tready, exactly 8 transfers.
- Truncation: MAX_PACKET_LENGTH=8, s0 sends a 12-beat packet -> 8 beats forwarded with m_tlast on beat 8, trunc_o pulses once, beats 9-12 are consumed with m_tvalid=0, then the arbiter returns to IDLE. A 9th-beat-free 8-beat packet with its own tlast -> trunc_o stays 0.
- Enable gating: en1_i=0 while s1 is valid -> s1 is never granted. en0_i dropped mid-packet -> the s0 packet still completes.
- Reset mid-packet: assert reset on beat 3 of a 6-beat packet -> the next cycle has m_tvalid=0, grant_o=0, busy_o=0, and the next grant after release goes to s0.

Source files
------------

// File: rtl/usb_ddr3_stream_arbiter_if.sv
// 8-bit AXI-Stream link used between the requesters, the arbiter and the
// DDR3 write-stream sink. The master drives data/valid, the slave drives ready.
interface usb_ddr3_stream_arbiter_if;
   logic       tvalid;
   logic       tready;
   logic       tkeep;
   logic       tlast;
   logic [7:0] tdata;

   modport master (
      output tvalid,
      output tkeep,
      output tlast,
      output tdata,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tkeep,
      input  tlast,
      input  tdata,
      output tready
   );
endinterface

// File: rtl/usb_ddr3_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one DDR3 write-stream sink
// between USB bulk-out (s0) and a local pattern/loopback source (s1).
// A grant is held until the packet's tlast is accepted; packets longer than
// MAX_PACKET_LENGTH beats get a forced tlast and their tail is discarded.
module usb_ddr3_stream_arbiter #(
   parameter  int MAX_PACKET_LENGTH = 512,
   localparam int CBITS             = $clog2(MAX_PACKET_LENGTH) + 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         en0_i,
   input  logic                         en1_i,
   usb_ddr3_stream_arbiter_if.slave     s0,
   usb_ddr3_stream_arbiter_if.slave     s1,
   usb_ddr3_stream_arbiter_if.master    m,
   output logic [1:0]                   grant_o,
   output logic                         busy_o,
   output logic                         trunc_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   // Count value of the last beat that may be forwarded in one packet.
   localparam logic [CBITS-1:0] LAST_BEAT = CBITS'(MAX_PACKET_LENGTH - 1);

   state_t           state_reg, state_next;
   logic [1:0]       grant_reg, grant_next;
   logic [CBITS-1:0] count_reg, count_next;
   logic             ptr_reg, ptr_next;      // 0 favours s0, 1 favours s1
   logic             trunc_reg, trunc_next;

   // Granted-source view (sel=1 means s1 owns the sink).
   logic             sel;
   logic             g_tvalid;
   logic             g_tlast;
   logic             g_tkeep;
   logic [7:0]       g_tdata;
   logic             req0, req1;
   logic             at_limit;
   logic             m_valid_c;
   logic             src_ready_c;

   assign sel      = grant_reg[1];
   assign g_tvalid = sel ? s1.tvalid : s0.tvalid;
   assign g_tlast  = sel ? s1.tlast  : s0.tlast;
   assign g_tkeep  = sel ? s1.tkeep  : s0.tkeep;
   assign g_tdata  = sel ? s1.tdata  : s0.tdata;

   assign req0     = s0.tvalid & en0_i;
   assign req1     = s1.tvalid & en1_i;
   assign at_limit = (count_reg == LAST_BEAT);

   // State, grant, beat count, priority pointer and truncation pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         grant_reg <= 2'b00;
         count_reg <= '0;
         ptr_reg   <= 1'b0;
         trunc_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         count_reg <= count_next;
         ptr_reg   <= ptr_next;
         trunc_reg <= trunc_next;
      end
   end

   // Arbitration, pass-through handshake and packet-end / truncation decisions.
   always_comb begin
      state_next  = state_reg;
      grant_next  = grant_reg;
      count_next  = count_reg;
      ptr_next    = ptr_reg;
      trunc_next  = 1'b0;
      m_valid_c   = 1'b0;
      src_ready_c = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (req0 || req1) begin
               // s0 wins when it is the only requester or the pointer favours it.
               if (req0 && (!req1 || !ptr_reg)) begin
                  grant_next = 2'b01;
               end else begin
                  grant_next = 2'b10;
               end
               count_next = '0;
               state_next = ST_BUSY;
            end
         end

         ST_BUSY: begin
            m_valid_c   = g_tvalid;
            src_ready_c = m.tready;
            if (g_tvalid && m.tready) begin
               count_next = count_reg + CBITS'(1);
               if (g_tlast) begin
                  // Natural end of packet, including a tlast exactly on the limit.
                  state_next = ST_IDLE;
                  grant_next = 2'b00;
                  ptr_next   = ~sel;
               end else if (at_limit) begin
                  // Forced tlast went out; swallow the rest of the source packet.
                  trunc_next = 1'b1;
                  state_next = ST_DROP;
                  ptr_next   = ~ptr_reg;
               end
            end
         end

         ST_DROP: begin
            src_ready_c = 1'b1;
            if (g_tvalid && g_tlast) begin
               state_next = ST_IDLE;
               grant_next = 2'b00;
            end
         end

         default: begin
            state_next = ST_IDLE;
            grant_next = 2'b00;
         end
      endcase
   end

   assign m.tvalid  = m_valid_c;
   assign m.tdata   = g_tdata;
   assign m.tkeep   = g_tkeep;
   assign m.tlast   = (state_reg == ST_BUSY) & (g_tlast | at_limit);

   assign s0.tready = src_ready_c & ~sel;
   assign s1.tready = src_ready_c &  sel;

   assign grant_o   = grant_reg;
   assign busy_o    = (state_reg != ST_IDLE);
   assign trunc_o   = trunc_reg;

endmodule

// File: tb/tb_usb_ddr3_stream_arbiter.sv
// Directed bench for usb_ddr3_stream_arbiter (MAX_PACKET_LENGTH=8).
// Source queues feed two AXI-S drivers; a packet-level model produces the
// expected output beat stream, checked by one per-cycle compare process.
module tb_usb_ddr3_stream_arbiter;
   localparam int MAXL = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic [1:0] grant;
      beat_t      b;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic en0   = 1'b1;
   logic en1   = 1'b1;
   logic [1:0] grant_o;
   logic busy_o;
   logic trunc_o;

   usb_ddr3_stream_arbiter_if s0_if ();
   usb_ddr3_stream_arbiter_if s1_if ();
   usb_ddr3_stream_arbiter_if m_if ();

   usb_ddr3_stream_arbiter #(.MAX_PACKET_LENGTH(MAXL)) dut (
      .clock   (clock),
      .reset   (reset),
      .en0_i   (en0),
      .en1_i   (en1),
      .s0      (s0_if),
      .s1      (s1_if),
      .m       (m_if),
      .grant_o (grant_o),
      .busy_o  (busy_o),
      .trunc_o (trunc_o)
   );

   always #5 clock = ~clock;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  exp_q[$];
   exp_t  e_cur;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;
   int xfer_cnt = 0;
   int trunc_cnt = 0;
   int g1_seen  = 0;
   int exp_trunc = 0;
   bit bp_chk   = 0;
   bit arm      = 0;
   int t_sv     = -1;
   int t_mx     = -1;
   logic [7:0] first_data, last_data;
   logic [1:0] first_grant;
   bit fire0, fire1;

   function automatic void chk(input bit ok, input string nm, input longint act, input longint expv);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
   endfunction

   function automatic beat_t gen_beat(input int i, input int len, input logic [7:0] base, input bit kz);
      beat_t b;
      b.data = 8'(int'(base) * (i + 1));
      b.keep = !(kz && (i % 4 == 1));
      b.last = (i == len - 1);
      return b;
   endfunction

   task automatic send(input int src, input int len, input logic [7:0] base, input bit kz);
      for (int i = 0; i < len; i++) begin
         if (src == 0) q0.push_back(gen_beat(i, len, base, kz));
         else          q1.push_back(gen_beat(i, len, base, kz));
      end
   endtask

   // Packet-level model: at most MAXL beats leave, the last one always carries tlast.
   task automatic expect_pkt(input int src, input int len, input logic [7:0] base, input bit kz);
      exp_t e;
      int n;
      n = (len < MAXL) ? len : MAXL;
      for (int i = 0; i < n; i++) begin
         e.b      = gen_beat(i, len, base, kz);
         e.b.last = (i == len - 1) || (i == MAXL - 1);
         e.grant  = (src == 0) ? 2'b01 : 2'b10;
         exp_q.push_back(e);
      end
      if (len > MAXL) exp_trunc++;
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_done(input int budget, input bit toggle, input bit ignore_s1);
      int k;
      bit done;
      k = 0;
      done = 0;
      while (!done && k < budget) begin
         if (toggle) m_if.tready = (k % 4 == 0) || (k % 4 == 3);
         step();
         k++;
         done = (exp_q.size() == 0) && (q0.size() == 0) && !s0_if.tvalid && !busy_o &&
                (ignore_s1 || ((q1.size() == 0) && !s1_if.tvalid));
      end
      chk(done, "wait_done_timeout", k, budget);
      m_if.tready = 1'b1;
   endtask

   // Source 0 driver: advance on an accepted beat, present the queue head.
   initial begin
      s0_if.tvalid = 0; s0_if.tkeep = 0; s0_if.tlast = 0; s0_if.tdata = 0;
      forever begin
         @(negedge clock);
         fire0 = s0_if.tvalid && s0_if.tready;
         @(posedge clock);
         #1;
         if (fire0 && q0.size() > 0) q0.delete(0);
         if (q0.size() > 0) begin
            s0_if.tvalid = 1'b1;
            {s0_if.tdata, s0_if.tkeep, s0_if.tlast} = q0[0];
         end else begin
            s0_if.tvalid = 1'b0;
            s0_if.tlast  = 1'b0;
         end
      end
   end

   // Source 1 driver.
   initial begin
      s1_if.tvalid = 0; s1_if.tkeep = 0; s1_if.tlast = 0; s1_if.tdata = 0;
      forever begin
         @(negedge clock);
         fire1 = s1_if.tvalid && s1_if.tready;
         @(posedge clock);
         #1;
         if (fire1 && q1.size() > 0) q1.delete(0);
         if (q1.size() > 0) begin
            s1_if.tvalid = 1'b1;
            {s1_if.tdata, s1_if.tkeep, s1_if.tlast} = q1[0];
         end else begin
            s1_if.tvalid = 1'b0;
            s1_if.tlast  = 1'b0;
         end
      end
   end

   // Compare process: every accepted output beat against the model stream.
   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (!reset) begin
            if (arm && t_sv < 0 && s0_if.tvalid) t_sv = cyc;
            if (m_if.tvalid && m_if.tready) begin
               xfer_cnt++;
               if (arm && t_mx < 0) begin
                  t_mx        = cyc;
                  first_data  = m_if.tdata;
                  first_grant = grant_o;
               end
               last_data = m_if.tdata;
               if (exp_q.size() == 0) begin
                  chk(0, "unexpected_xfer", {grant_o, m_if.tdata, m_if.tkeep, m_if.tlast}, 0);
               end else begin
                  e_cur = exp_q.pop_front();
                  chk({grant_o, m_if.tdata, m_if.tkeep, m_if.tlast} == e_cur, "xfer",
                      {grant_o, m_if.tdata, m_if.tkeep, m_if.tlast}, e_cur);
               end
            end
            chk(busy_o == (grant_o != 2'b00), "busy_vs_grant", {busy_o, grant_o}, {grant_o != 2'b00, grant_o});
            if (trunc_o) trunc_cnt++;
            if (grant_o[1]) g1_seen++;
            if (bp_chk && grant_o == 2'b10 && m_if.tvalid)
               chk(s1_if.tready == m_if.tready && !s0_if.tready, "bp_ready",
                   {s0_if.tready, s1_if.tready}, {1'b0, m_if.tready});
         end
      end
   end

   // Directed scenarios.
   initial begin
      int x0, t0, g0, k;
      m_if.tready = 1'b1;
      reset = 1'b1;
      repeat (3) step();
      chk(m_if.tvalid == 0, "rst_m_tvalid", m_if.tvalid, 0);
      chk(grant_o == 0, "rst_grant", grant_o, 0);
      chk(busy_o == 0 && trunc_o == 0, "rst_busy_trunc", {busy_o, trunc_o}, 0);
      chk(s0_if.tready == 0 && s1_if.tready == 0, "rst_tready", {s0_if.tready, s1_if.tready}, 0);
      reset = 1'b0;
      step();

      // Single source, 4 beats.
      arm = 1; t_sv = -1; t_mx = -1;
      send(0, 4, 8'h11, 0);
      expect_pkt(0, 4, 8'h11, 0);
      wait_done(100, 0, 0);
      arm = 0;
      chk(t_mx - t_sv == 1, "first_beat_latency", t_mx - t_sv, 1);
      chk(first_data == 8'h11, "t1_first_data", first_data, 8'h11);
      chk(last_data == 8'h44, "t1_last_data", last_data, 8'h44);
      chk(first_grant == 2'b01, "t1_grant", first_grant, 2'b01);
      chk(grant_o == 2'b00, "t1_grant_after", grant_o, 0);

      // Contention after reset: s0, s1, s0.
      reset = 1'b1; step(); step(); reset = 1'b0;
      x0 = xfer_cnt;
      send(0, 3, 8'h01, 0);
      send(0, 3, 8'h03, 0);
      send(1, 3, 8'h05, 0);
      expect_pkt(0, 3, 8'h01, 0);
      expect_pkt(1, 3, 8'h05, 0);
      expect_pkt(0, 3, 8'h03, 0);
      wait_done(200, 0, 0);
      chk(xfer_cnt - x0 == 9, "contention_xfers", xfer_cnt - x0, 9);

      // Backpressure, 8-beat s1 packet ending exactly on the limit.
      bp_chk = 1; x0 = xfer_cnt; t0 = trunc_cnt;
      send(1, 8, 8'h13, 1);
      expect_pkt(1, 8, 8'h13, 1);
      wait_done(200, 1, 0);
      bp_chk = 0;
      chk(xfer_cnt - x0 == 8, "bp_xfer_count", xfer_cnt - x0, 8);
      chk(trunc_cnt - t0 == 0, "bp_no_trunc", trunc_cnt - t0, 0);

      // Truncation of a 12-beat packet.
      x0 = xfer_cnt; t0 = trunc_cnt;
      send(0, 12, 8'h11, 0);
      expect_pkt(0, 12, 8'h11, 0);
      chk(exp_q.size() == 8, "model_trunc_len", exp_q.size(), 8);
      chk(exp_q[7].b == {8'h88, 1'b1, 1'b1}, "model_trunc_last", exp_q[7].b, {8'h88, 1'b1, 1'b1});
      chk(exp_q[6].b.last == 1'b0, "model_beat7_nolast", exp_q[6].b.last, 0);
      wait_done(200, 0, 0);
      chk(xfer_cnt - x0 == 8, "trunc_xfers", xfer_cnt - x0, 8);
      chk(trunc_cnt - t0 == 1, "trunc_pulses", trunc_cnt - t0, 1);
      chk(trunc_cnt == exp_trunc, "trunc_total", trunc_cnt, exp_trunc);

      // Enable gating.
      en1 = 1'b0; g0 = g1_seen;
      send(1, 2, 8'h40, 0);
      repeat (20) step();
      chk(g1_seen == g0, "en1_gated", g1_seen - g0, 0);
      chk(busy_o == 1'b0, "en1_idle", busy_o, 0);
      x0 = xfer_cnt;
      send(0, 6, 8'h07, 0);
      expect_pkt(0, 6, 8'h07, 0);
      repeat (4) step();
      en0 = 1'b0;
      wait_done(200, 0, 1);
      chk(xfer_cnt - x0 == 6, "en0_drop_completes", xfer_cnt - x0, 6);
      en0 = 1'b1; en1 = 1'b1;
      expect_pkt(1, 2, 8'h40, 0);
      wait_done(200, 0, 0);
      chk(g1_seen > g0, "en1_released", g1_seen - g0, 1);

      // Reset mid-packet; pointer first steered to s1 by an s0 packet.
      send(0, 1, 8'hA0, 0);
      expect_pkt(0, 1, 8'hA0, 0);
      wait_done(100, 0, 0);
      x0 = xfer_cnt;
      send(0, 6, 8'h0B, 0);
      expect_pkt(0, 6, 8'h0B, 0);
      k = 0;
      while (xfer_cnt - x0 < 2 && k < 100) begin
         step();
         k++;
      end
      chk(xfer_cnt - x0 == 2, "rst_mid_reached_beat3", xfer_cnt - x0, 2);
      reset = 1'b1;
      q0.delete();
      s0_if.tvalid = 1'b0;
      exp_q.delete();
      step();
      chk(m_if.tvalid == 0 && m_if.tlast == 0, "rst_mid_m_valid_last", {m_if.tvalid, m_if.tlast}, 0);
      chk(grant_o == 0, "rst_mid_grant", grant_o, 0);
      chk(busy_o == 0, "rst_mid_busy", busy_o, 0);
      reset = 1'b0;
      send(1, 2, 8'h50, 0);
      send(0, 2, 8'h60, 0);
      expect_pkt(0, 2, 8'h60, 0);
      expect_pkt(1, 2, 8'h50, 0);
      wait_done(200, 0, 0);

      repeat (3) step();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "time limit");
   end

endmodule
